// File: rtl/frame_draw_scheduler.sv
// Per-frame draw sequencer: scrolled background sweep, then sprite overlay,
// feeding the single VGA adapter write port through a one-stage ROM pipeline.
module frame_draw_scheduler #(
  parameter int XSCREEN = 160,
  parameter int YSCREEN = 120,
  parameter int SCROLL_SPEED = 1,
  parameter int SPR_W = 8,
  parameter int SPR_H = 12,
  parameter int SPR_AW = 7,
  parameter int COLOUR_W = 3,
  parameter logic [COLOUR_W-1:0] TRANSPARENT = '0
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                frame_tick,
  input  logic [7:0]          car_x,
  input  logic [6:0]          car_y,
  output logic [14:0]         bg_addr,
  input  logic [COLOUR_W-1:0] bg_data,
  output logic [SPR_AW-1:0]   spr_addr,
  input  logic [COLOUR_W-1:0] spr_data,
  output logic [7:0]          x,
  output logic [6:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done,
  output logic                overrun,
  output logic [6:0]          scroll_offset
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BG   = 2'd1;
  localparam logic [1:0] S_SPR  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0] state_q, state_d;
  logic [7:0] col_q, col_d;
  logic [6:0] row_q, row_d;
  logic [7:0] sx_q, sx_d;
  logic [6:0] sy_q, sy_d;
  logic [7:0] carx_q, carx_d;
  logic [6:0] cary_q, cary_d;
  logic pending_q, pending_d;
  logic overrun_q, overrun_d;
  logic [6:0] offset_q, offset_d;
  logic stg_vld_q, stg_vld_d;
  logic stg_spr_q, stg_spr_d;
  logic [8:0] stg_x_q, stg_x_d;
  logic [7:0] stg_y_q, stg_y_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;

  logic [7:0] src_sum, src_row, off_sum;
  logic [14:0] bg_lin;
  logic [15:0] spr_lin;
  logic last_bg, last_spr, spr_vis, plot_c;

  // Background row is fetched from the scrolled source row, wrapped once
  always_comb begin
    src_sum = {1'b0, row_q} + {1'b0, offset_q};
    src_row = (src_sum >= 8'(YSCREEN)) ? src_sum - 8'(YSCREEN) : src_sum;
    bg_lin  = 15'(src_row) * 15'(XSCREEN) + 15'(col_q);
    spr_lin = 16'(sy_q) * 16'(SPR_W) + 16'(sx_q);
    off_sum = {1'b0, offset_q} + 8'(SCROLL_SPEED);
    last_bg  = (col_q == 8'(XSCREEN - 1)) && (row_q == 7'(YSCREEN - 1));
    last_spr = (sx_q == 8'(SPR_W - 1)) && (sy_q == 7'(SPR_H - 1));
  end

  assign bg_addr  = (state_q == S_BG) ? bg_lin : '0;
  assign spr_addr = (state_q == S_SPR) ? SPR_AW'(spr_lin) : '0;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign overrun  = overrun_q;
  assign scroll_offset = offset_q;

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    carx_d    = carx_q;
    cary_d    = cary_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    offset_d  = offset_q;
    stg_vld_d = 1'b0;
    stg_spr_d = stg_spr_q;
    stg_x_d   = stg_x_q;
    stg_y_d   = stg_y_q;
    if (frame_tick && pending_q) overrun_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (frame_tick || pending_q) begin
          state_d   = S_BG;
          pending_d = 1'b0;
          carx_d    = car_x;
          cary_d    = car_y;
          col_d     = '0;
          row_d     = '0;
        end
      end
      S_BG: begin
        if (frame_tick) pending_d = 1'b1;
        stg_vld_d = 1'b1;
        stg_spr_d = 1'b0;
        stg_x_d   = {1'b0, col_q};
        stg_y_d   = {1'b0, row_q};
        if (last_bg) begin
          state_d = S_SPR;
          sx_d    = '0;
          sy_d    = '0;
        end else if (col_q == 8'(XSCREEN - 1)) begin
          col_d = '0;
          row_d = row_q + 7'd1;
        end else begin
          col_d = col_q + 8'd1;
        end
      end
      S_SPR: begin
        if (frame_tick) pending_d = 1'b1;
        stg_vld_d = 1'b1;
        stg_spr_d = 1'b1;
        stg_x_d   = {1'b0, carx_q} + {1'b0, sx_q};
        stg_y_d   = {1'b0, cary_q} + {1'b0, sy_q};
        if (last_spr) begin
          state_d = S_DONE;
        end else if (sx_q == 8'(SPR_W - 1)) begin
          sx_d = '0;
          sy_d = sy_q + 7'd1;
        end else begin
          sx_d = sx_q + 8'd1;
        end
      end
      default: begin
        if (frame_tick) pending_d = 1'b1;
        offset_d = (off_sum >= 8'(YSCREEN)) ?
                   7'(off_sum - 8'(YSCREEN)) : 7'(off_sum);
        state_d  = S_IDLE;
      end
    endcase
  end

  // ROM data lands alongside the staged coordinates; hold x/y/colour when idle
  always_comb begin
    spr_vis  = (stg_x_q < 9'(XSCREEN)) && (stg_y_q < 8'(YSCREEN)) &&
               (spr_data != TRANSPARENT);
    plot_c   = stg_vld_q && (!stg_spr_q || spr_vis);
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    if (plot_c) begin
      x_d      = stg_x_q[7:0];
      y_d      = stg_y_q[6:0];
      colour_d = stg_spr_q ? spr_data : bg_data;
    end
  end

  assign plot   = plot_c;
  assign x      = x_d;
  assign y      = y_d;
  assign colour = colour_d;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      row_q     <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      carx_q    <= '0;
      cary_q    <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      offset_q  <= '0;
      stg_vld_q <= 1'b0;
      stg_spr_q <= 1'b0;
      stg_x_q   <= '0;
      stg_y_q   <= '0;
      x_q       <= '0;
      y_q       <= '0;
      colour_q  <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      carx_q    <= carx_d;
      cary_q    <= cary_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      offset_q  <= offset_d;
      stg_vld_q <= stg_vld_d;
      stg_spr_q <= stg_spr_d;
      stg_x_q   <= stg_x_d;
      stg_y_q   <= stg_y_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
    end
  end

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Directed bench: full-size instance for frame timing and reset, plus a
// reduced 20x16 instance for scroll wrap, sprite, clipping and tick handling.
module tb_frame_draw_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int spr_mode = 0;
  int s_exp_off = 0;

  logic a_rst, a_tick, a_plot, a_busy, a_done, a_ovr;
  logic [7:0] a_cx, a_x;
  logic [6:0] a_cy, a_y, a_off, a_spr_addr;
  logic [14:0] a_bg_addr;
  logic [2:0] a_bg_data, a_spr_data, a_colour;

  logic s_rst, s_tick, s_plot, s_busy, s_done, s_ovr;
  logic [7:0] s_cx, s_x;
  logic [6:0] s_cy, s_y, s_off, s_spr_addr;
  logic [14:0] s_bg_addr;
  logic [2:0] s_bg_data, s_spr_data, s_colour;

  frame_draw_scheduler dut_a (
    .CLOCK_50(clk), .reset(a_rst), .frame_tick(a_tick),
    .car_x(a_cx), .car_y(a_cy),
    .bg_addr(a_bg_addr), .bg_data(a_bg_data),
    .spr_addr(a_spr_addr), .spr_data(a_spr_data),
    .x(a_x), .y(a_y), .colour(a_colour), .plot(a_plot),
    .busy(a_busy), .done(a_done), .overrun(a_ovr),
    .scroll_offset(a_off)
  );

  frame_draw_scheduler #(.XSCREEN(20), .YSCREEN(16)) dut_s (
    .CLOCK_50(clk), .reset(s_rst), .frame_tick(s_tick),
    .car_x(s_cx), .car_y(s_cy),
    .bg_addr(s_bg_addr), .bg_data(s_bg_data),
    .spr_addr(s_spr_addr), .spr_data(s_spr_data),
    .x(s_x), .y(s_y), .colour(s_colour), .plot(s_plot),
    .busy(s_busy), .done(s_done), .overrun(s_ovr),
    .scroll_offset(s_off)
  );

  function automatic logic [2:0] bgf(input int a);
    return 3'(a ^ (a >> 3) ^ (a >> 7));
  endfunction

  function automatic logic [2:0] sprf(input int a, input int m);
    if (m == 0) return 3'd0;
    if (m == 1 && (a % 2) == 0) return 3'd0;
    return 3'((a % 7) + 1);
  endfunction

  always @(posedge clk) begin
    a_bg_data  <= bgf(int'(a_bg_addr));
    a_spr_data <= sprf(int'(a_spr_addr), spr_mode);
    s_bg_data  <= bgf(int'(s_bg_addr));
    s_spr_data <= sprf(int'(s_spr_addr), spr_mode);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a_rst = 1'b1; s_rst = 1'b1;
    step; step;
    total++;
    if ({a_plot, a_busy, a_done, a_ovr} !== 4'b0) begin
      bad++; $display("FAIL rst_a_flags got=%b want=0000", {a_plot, a_busy, a_done, a_ovr});
    end
    total++;
    if ({a_off, a_x, a_y, a_colour} !== '0) begin
      bad++; $display("FAIL rst_a_pix off=%0d x=%0d y=%0d c=%0d want all 0", a_off, a_x, a_y, a_colour);
    end
    total++;
    if ({a_bg_addr, a_spr_addr} !== '0) begin
      bad++; $display("FAIL rst_a_addr bg=%0d spr=%0d want 0", a_bg_addr, a_spr_addr);
    end
    total++;
    if ({s_plot, s_busy, s_done, s_ovr, s_off, s_x, s_y, s_colour} !== '0) begin
      bad++; $display("FAIL rst_s_outs got nonzero want 0");
    end
    a_rst = 1'b0; s_rst = 1'b0;
    step;
  endtask

  task automatic test_first_frame;
    int errs, nplot, dk, idx;
    logic first_ok;
    spr_mode = 0; a_cx = 8'd50; a_cy = 7'd40;
    a_tick = 1'b1; step; a_tick = 1'b0;
    total++;
    if (a_busy !== 1'b1 || a_bg_addr !== 15'd0 || a_plot !== 1'b0) begin
      bad++; $display("FAIL start_k1 busy=%b addr=%0d plot=%b want 1 0 0", a_busy, a_bg_addr, a_plot);
    end
    errs = 0; nplot = 0; dk = -1; first_ok = 1'b0;
    for (int k = 2; k <= 20000; k++) begin
      step;
      if (k == 2) first_ok = a_plot && a_x == 8'd0 && a_y == 7'd0;
      if (a_plot) begin
        nplot++;
        if (k <= 19201) begin
          idx = k - 2;
          if (a_x !== 8'(idx % 160) || a_y !== 7'(idx / 160) || a_colour !== bgf(idx)) errs++;
        end else errs++;
      end else if (k <= 19201) errs++;
      if (a_done) begin dk = k; break; end
    end
    total++;
    if (!first_ok) begin bad++; $display("FAIL first_plot got=0 want=1 (plot at 0,0)"); end
    total++;
    if (nplot != 19200) begin bad++; $display("FAIL bg_plot_count got=%0d want=19200", nplot); end
    total++;
    if (errs != 0) begin bad++; $display("FAIL bg_sweep errs=%0d want=0", errs); end
    total++;
    if (dk != 19297) begin bad++; $display("FAIL done_cycle got=%0d want=19297", dk); end
    step;
    total++;
    if (a_off !== 7'd1 || a_busy !== 1'b0) begin
      bad++; $display("FAIL offset_after off=%0d busy=%b want 1 0", a_off, a_busy);
    end
  endtask

  task automatic test_midframe_reset;
    int nd;
    a_rst = 1'b1; step; a_rst = 1'b0; step;
    a_tick = 1'b1; step; a_tick = 1'b0;
    repeat (4999) step;
    total++;
    if (a_plot !== 1'b1) begin bad++; $display("FAIL mid_plot got=%b want=1", a_plot); end
    a_rst = 1'b1;
    #1;
    total++;
    if (a_plot !== 1'b0 || a_busy !== 1'b0 || a_off !== 7'd0) begin
      bad++; $display("FAIL mid_reset plot=%b busy=%b off=%0d want 0 0 0", a_plot, a_busy, a_off);
    end
    total++;
    if (a_x !== 8'd0 || a_y !== 7'd0) begin
      bad++; $display("FAIL mid_reset_xy x=%0d y=%0d want 0 0", a_x, a_y);
    end
    step; step;
    a_rst = 1'b0;
    nd = 0;
    repeat (30) begin step; if (a_done || a_busy) nd++; end
    total++;
    if (nd != 0) begin bad++; $display("FAIL mid_no_done got=%0d want=0", nd); end
    a_tick = 1'b1; step; a_tick = 1'b0;
    total++;
    if (a_bg_addr !== 15'd0) begin bad++; $display("FAIL restart_addr got=%0d want=0", a_bg_addr); end
    step;
    total++;
    if (a_plot !== 1'b1 || a_x !== 8'd0 || a_y !== 7'd0) begin
      bad++; $display("FAIL restart_pix plot=%b x=%0d y=%0d want 1 0 0", a_plot, a_x, a_y);
    end
    a_rst = 1'b1; step; a_rst = 1'b0;
  endtask

  task automatic frame_small(input logic [7:0] cx, input logic [6:0] cy,
                             output int sprn, output int errs, output int oob,
                             output int dk, output int a1, output int a21);
    int idx, row, col, src, a, px, py, vis;
    logic [2:0] c;
    s_cx = cx; s_cy = cy;
    s_tick = 1'b1; step; s_tick = 1'b0;
    a1 = int'(s_bg_addr); a21 = -1;
    sprn = 0; errs = 0; oob = 0; dk = -1;
    for (int k = 2; k <= 1000; k++) begin
      step;
      if (k == 21) a21 = int'(s_bg_addr);
      if (s_plot && (s_x >= 8'd20 || s_y >= 7'd16)) oob++;
      if (k <= 321) begin
        idx = k - 2; row = idx / 20; col = idx % 20;
        src = (row + s_exp_off) % 16;
        if (s_plot !== 1'b1 || s_x !== 8'(col) || s_y !== 7'(row) ||
            s_colour !== bgf(src * 20 + col)) errs++;
      end else if (k <= 417) begin
        a = k - 322;
        px = int'(cx) + a % 8; py = int'(cy) + a / 8;
        c = sprf(a, spr_mode);
        vis = (px < 20 && py < 16 && c != 3'd0) ? 1 : 0;
        if (s_plot !== 1'(vis)) errs++;
        else if (vis == 1) begin
          sprn++;
          if (s_x !== 8'(px) || s_y !== 7'(py) || s_colour !== c) errs++;
        end
      end
      if (s_done) begin dk = k; break; end
    end
    s_exp_off = (s_exp_off + 1) % 16;
    step;
  endtask

  task automatic test_scroll_wrap;
    int sprn, errs, oob, dk, a1, a21, e_sum, d_ok;
    spr_mode = 0; e_sum = 0; d_ok = 0;
    for (int f = 0; f < 15; f++) begin
      frame_small(8'd0, 7'd0, sprn, errs, oob, dk, a1, a21);
      e_sum += errs;
      if (dk == 417) d_ok++;
    end
    total++;
    if (e_sum != 0 || d_ok != 15) begin
      bad++; $display("FAIL scroll_frames errs=%0d done_ok=%0d want 0 15", e_sum, d_ok);
    end
    total++;
    if (s_off !== 7'd15) begin bad++; $display("FAIL offset_15 got=%0d want=15", s_off); end
    frame_small(8'd0, 7'd0, sprn, errs, oob, dk, a1, a21);
    total++;
    if (a1 != 300) begin bad++; $display("FAIL wrap_row0 got=%0d want=300", a1); end
    total++;
    if (a21 != 0) begin bad++; $display("FAIL wrap_row1 got=%0d want=0", a21); end
    total++;
    if (errs != 0 || dk != 417) begin
      bad++; $display("FAIL wrap_frame errs=%0d done=%0d want 0 417", errs, dk);
    end
    total++;
    if (s_off !== 7'd0) begin bad++; $display("FAIL offset_wrap got=%0d want=0", s_off); end
  endtask

  task automatic test_transparency;
    int sprn, errs, oob, dk, a1, a21;
    spr_mode = 1;
    frame_small(8'd10, 7'd2, sprn, errs, oob, dk, a1, a21);
    total++;
    if (sprn != 48) begin bad++; $display("FAIL transp_count got=%0d want=48", sprn); end
    total++;
    if (errs != 0) begin bad++; $display("FAIL transp_pixels errs=%0d want=0", errs); end
  endtask

  task automatic test_clipping;
    int sprn, errs, oob, dk, a1, a21;
    spr_mode = 2;
    frame_small(8'd15, 7'd11, sprn, errs, oob, dk, a1, a21);
    total++;
    if (sprn != 25) begin bad++; $display("FAIL clip_count got=%0d want=25", sprn); end
    total++;
    if (oob != 0 || errs != 0) begin
      bad++; $display("FAIL clip_pixels oob=%0d errs=%0d want 0 0", oob, errs);
    end
  endtask

  task automatic test_overrun;
    int nd, d1, s2;
    spr_mode = 0; s_cx = 8'd0; s_cy = 7'd0;
    nd = 0; d1 = -1; s2 = -1;
    s_tick = 1'b1; step; s_tick = 1'b0;
    for (int k = 1; k <= 1200; k++) begin
      s_tick = (k == 100 || k == 200);
      if (k == 101) begin
        total++;
        if (s_ovr !== 1'b0) begin bad++; $display("FAIL ovr_early got=%b want=0", s_ovr); end
      end
      if (k == 201) begin
        total++;
        if (s_ovr !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b want=1", s_ovr); end
      end
      if (s_done) begin nd++; if (d1 < 0) d1 = k; end
      if (d1 > 0 && k > d1 && s2 < 0 && s_busy) s2 = k;
      step;
    end
    s_tick = 1'b0;
    s_exp_off = (s_exp_off + 2) % 16;
    total++;
    if (nd != 2) begin bad++; $display("FAIL ovr_done_count got=%0d want=2", nd); end
    total++;
    if (d1 != 417 || s2 != 419) begin
      bad++; $display("FAIL ovr_restart done=%0d start=%0d want 417 419", d1, s2);
    end
    total++;
    if (s_ovr !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b want=1", s_ovr); end
  endtask

  task automatic test_back_to_back;
    int nd, d1, s2, a419, e419;
    spr_mode = 0;
    nd = 0; d1 = -1; s2 = -1; a419 = -1;
    e419 = ((s_exp_off + 1) % 16) * 20;
    s_tick = 1'b1; step; s_tick = 1'b0;
    for (int k = 1; k <= 1000; k++) begin
      s_tick = (k == 417);
      if (k == 419) a419 = int'(s_bg_addr);
      if (s_done) begin nd++; if (d1 < 0) d1 = k; end
      if (d1 > 0 && k > d1 && s2 < 0 && s_busy) s2 = k;
      step;
    end
    s_tick = 1'b0;
    s_exp_off = (s_exp_off + 2) % 16;
    total++;
    if (d1 != 417 || s2 != 419) begin
      bad++; $display("FAIL b2b_restart done=%0d start=%0d want 417 419", d1, s2);
    end
    total++;
    if (a419 != e419) begin bad++; $display("FAIL b2b_addr got=%0d want=%0d", a419, e419); end
    total++;
    if (nd != 2) begin bad++; $display("FAIL b2b_done_count got=%0d want=2", nd); end
  endtask

  initial begin
    a_rst = 1'b1; s_rst = 1'b1;
    a_tick = 1'b0; s_tick = 1'b0;
    a_cx = '0; a_cy = '0; s_cx = '0; s_cy = '0;
    test_reset;
    test_first_frame;
    test_midframe_reset;
    test_scroll_wrap;
    test_transparency;
    test_clipping;
    test_overrun;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
